// File: rtl/onoff_sched.sv
// Round-robin scheduler sharing one j/k driven on/off resource among N_REQ requesters.
// Define ONOFF_SCHED_TIMEOUT_EN for a sticky err when the resource fails to confirm in time.
`timescale 1ns/1ps
module onoff_sched #(
  parameter int N_REQ          = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic             dev_out,
  output logic             j,
  output logic             k,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             err
);

  localparam int IDX_W = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ON_REQ  = 2'd1;
  localparam logic [1:0] S_GRANT   = 2'd2;
  localparam logic [1:0] S_OFF_REQ = 2'd3;

  localparam int               CNT_TOP   = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES
                                                                          : TIMEOUT_CYCLES;
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_TOP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_REQ - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] last;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] pick;
  logic             found;

  // The counter parks at its top value instead of wrapping back to zero.
  assign cnt_inc = (cnt >= CNT_SAT) ? cnt : cnt + 1'b1;

  // Search upward from last+1 with wrap; the previous owner is visited last.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    cand  = last;
    pick  = last;
    found = 1'b0;
    for (int o = 0; o < N_REQ; o++) begin
      cand = (cand == IDX_LAST) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

`ifdef ONOFF_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic err_q;
`endif

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      sel   <= '0;
      last  <= IDX_LAST;
      cnt   <= '0;
`ifdef ONOFF_SCHED_TIMEOUT_EN
      err_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            sel   <= pick;
            cnt   <= '0;
            state <= S_ON_REQ;
          end
        end
        S_ON_REQ: begin
          if (!req[sel]) begin
            state <= S_OFF_REQ;
            cnt   <= '0;
          end else if (dev_out) begin
            state <= S_GRANT;
            cnt   <= '0;
          end
`ifdef ONOFF_SCHED_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
`endif
        end
        S_GRANT: begin
          if (!req[sel] || cnt == HOLD_LAST) begin
            state <= S_OFF_REQ;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_OFF_REQ: begin
          if (!dev_out) begin
            state <= S_IDLE;
            last  <= sel;
          end
`ifdef ONOFF_SCHED_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state so req/dev_out never reach them combinationally.
  assign j    = (state == S_ON_REQ);
  assign k    = (state == S_OFF_REQ);
  assign busy = (state != S_IDLE);

  always_comb begin
    gnt = '0;
    if (state == S_GRANT) gnt[sel] = 1'b1;
  end

`ifdef ONOFF_SCHED_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_onoff_sched.sv
// Randomized and directed bench for onoff_sched against a cycle-counting reference model.
// Follows ONOFF_SCHED_TIMEOUT_EN the same way the design does.
`timescale 1ns/1ps
module tb_onoff_sched;

  localparam int N    = 4;
  localparam int HOLD = 8;
  localparam int TOUT = 15;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] req     = '0;
  logic         dev_out = 1'b0;
  logic         j, k, busy, err;
  logic [N-1:0] gnt;

  onoff_sched #(
    .N_REQ(N), .HOLD_CYCLES(HOLD), .CNT_W(4), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .dev_out(dev_out),
    .j(j), .k(k), .gnt(gnt), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: phase of the current transaction plus plain cycle counts.
  typedef enum {P_IDLE, P_ON, P_GRANT, P_OFF} phase_t;
  phase_t ph;
  int     owner, last_owner, granted, waited;
  bit     m_err;
  int     dev_mode;  // 0: resource echoes j/k, 1: stuck off, 2: random latency echo

  task automatic model_reset();
    ph = P_IDLE; owner = 0; last_owner = N - 1; granted = 0; waited = 0; m_err = 1'b0;
  endtask

  function automatic int rr_pick(input int rv);
    for (int d = 1; d <= N; d++) begin
      int idx = (last_owner + d) % N;
      if (((rv >> idx) & 1) == 1) return idx;
    end
    return 0;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic d);
    int rv  = int'(r);
    bit own = ((rv >> owner) & 1) == 1;
    case (ph)
      P_IDLE:  if (rv != 0) begin owner = rr_pick(rv); waited = 1; ph = P_ON; end
      P_ON: begin
        if (!own)     begin ph = P_OFF; waited = 1; end
        else if (d)   begin ph = P_GRANT; granted = 1; end
`ifdef ONOFF_SCHED_TIMEOUT_EN
        else if (waited == TOUT) begin m_err = 1'b1; ph = P_IDLE; end
`endif
        else waited++;
      end
      P_GRANT: begin
        if (!own || granted == HOLD) begin ph = P_OFF; waited = 1; end
        else granted++;
      end
      P_OFF: begin
        if (!d) begin ph = P_IDLE; last_owner = owner; end
`ifdef ONOFF_SCHED_TIMEOUT_EN
        else if (waited == TOUT) begin m_err = 1'b1; ph = P_IDLE; end
`endif
        else waited++;
      end
    endcase
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    @(negedge clk);
    check("cyc_j",    32'(j),    32'(ph == P_ON));
    check("cyc_k",    32'(k),    32'(ph == P_OFF));
    check("cyc_busy", 32'(busy), 32'(ph != P_IDLE));
    check("cyc_gnt",  32'(gnt),  (ph == P_GRANT) ? (32'd1 << owner) : 32'd0);
    check("cyc_err",  32'(err),  32'(m_err));
  endtask

  // Drive inputs for the next rising edge; the resource reacts to last cycle's j/k.
  task automatic drive(input logic [N-1:0] r);
    case (dev_mode)
      0: begin if (j) dev_out = 1'b1; else if (k) dev_out = 1'b0; end
      1: dev_out = 1'b0;
      default: begin
        if (j && $urandom_range(0, 2) == 0)      dev_out = 1'b1;
        else if (k && $urandom_range(0, 2) == 0) dev_out = 1'b0;
      end
    endcase
    req = r;
    model_step(r, dev_out);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; dev_out = 1'b0; model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wind_down();
    dev_mode = 0;
    for (int i = 0; i < 50; i++) begin
      drive('0); tick();
      if (!busy) break;
    end
    check("wind_down_idle", 32'(busy), 32'd0);
  endtask

  logic [N-1:0] r;
  logic [N-1:0] prev_g;
  logic [N-1:0] rec [5];
  int           nrec, gcnt;
  bit           saw_k;

  initial begin
    dev_mode = 0;
    do_reset();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_gnt",  32'(gnt),  32'd0);

    // Single requester, resource echoes one cycle later.
    drive(4'b0100); tick();
    check("single_on_j", 32'(j), 32'd1);
    gcnt = 0; saw_k = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (k) begin saw_k = 1'b1; break; end
      drive(4'b0100); tick();
      if (gnt == 4'b0100) gcnt++;
    end
    check("single_reached_off", 32'(saw_k), 32'd1);
    check("single_gnt_cycles",  32'(gcnt),  32'd8);
    drive('0); tick();
    check("single_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a grant.
    drive(4'b0010); tick();
    drive(4'b0010); tick();
    drive(4'b0010); tick();
    check("pre_reset_gnt", 32'(gnt), 32'b0010);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_j",    32'(j),    32'd0);
    check("async_rst_k",    32'(k),    32'd0);
    check("async_rst_gnt",  32'(gnt),  32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    model_reset(); req = '0; dev_out = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Round robin with all requesters, then a 1001 pattern.
    nrec = 0; prev_g = '0; r = 4'b1111;
    for (int i = 0; i < 200; i++) begin
      drive(r); tick();
      if (gnt != 0 && prev_g == 0) begin rec[nrec] = gnt; nrec++; end
      prev_g = gnt;
      if (nrec >= 4 && k) r = 4'b1001;
      if (nrec == 5) break;
    end
    check("rr_count", 32'(nrec), 32'd5);
    check("rr_g0", 32'(rec[0]), 32'b0001);
    check("rr_g1", 32'(rec[1]), 32'b0010);
    check("rr_g2", 32'(rec[2]), 32'b0100);
    check("rr_g3", 32'(rec[3]), 32'b1000);
    check("rr_g4", 32'(rec[4]), 32'b0001);
    wind_down();

    // Early release on the third grant cycle.
    gcnt = 0; saw_k = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive(4'b0001); tick();
      if (gnt == 4'b0001) gcnt++;
      if (gcnt == 3) begin
        drive('0); tick();
        saw_k = k;
        check("early_gnt_dropped", 32'(gnt), 32'd0);
        break;
      end
    end
    check("early_off_next_edge", 32'(saw_k), 32'd1);
    wind_down();

    // Abort in ON_REQ with the resource stuck off.
    dev_mode = 1;
    drive(4'b0010); tick();
    check("abort_on_j", 32'(j), 32'd1);
    drive('0); tick();
    check("abort_off_k",   32'(k),   32'd1);
    check("abort_no_gnt",  32'(gnt), 32'd0);
    wind_down();

    // Resource never confirms turn-on.
    dev_mode = 1;
    drive(4'b1000); tick();
    repeat (15) begin drive(4'b1000); tick(); end
`ifdef ONOFF_SCHED_TIMEOUT_EN
    check("to_err",  32'(err),  32'd1);
    check("to_j",    32'(j),    32'd0);
    check("to_busy", 32'(busy), 32'd0);
    dev_mode = 0;
    prev_g = '0;
    for (int i = 0; i < 40; i++) begin
      drive(4'b1000); tick();
      prev_g = gnt;
      if (gnt != 0) break;
    end
    check("to_regrant",    32'(prev_g), 32'b1000);
    check("to_err_sticky", 32'(err),    32'd1);
    wind_down();
    do_reset();
    tick();
    check("to_err_cleared", 32'(err), 32'd0);
`else
    repeat (4) begin drive(4'b1000); tick(); end
    check("nto_j_held", 32'(j),   32'd1);
    check("nto_err",    32'(err), 32'd0);
    wind_down();
`endif

    // Randomized traffic with a random-latency resource.
    do_reset();
    dev_mode = 2;
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
      drive(r); tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onoff_sched.md
Name: onoff_sched

Overview:
- Round-robin scheduler that shares one two-state on/off resource among N_REQ requesters.
- The resource is a Moore on/off element driven by j (turn on) and k (turn off), with a 1-bit state output.
- Per grant the block turns the resource on, holds it for the winning requester, then turns it off before the next arbitration.
- Sits between requester logic and the on/off element. It drives j/k and reads back the element's state.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 8, maximum cycles a grant is held (>=1).
- CNT_W, 4, width of the hold/timeout counter; must hold max(HOLD_CYCLES, TIMEOUT_CYCLES).
- TIMEOUT_CYCLES, 15, cycles allowed for the resource to confirm a state change (used only with the optional feature).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  level request per requester.
- dev_out  input  1  state of the on/off resource (1 = on).
- j  output  1  turn-on command to the resource.
- k  output  1  turn-off command to the resource.
- gnt  output  N_REQ  one-hot grant, high only while granted and the resource is confirmed on.
- busy  output  1  high in any state other than IDLE.
- err  output  1  sticky timeout error.

Behaviour:
- One clock domain.
- reset_n low asynchronously forces: state=IDLE, last=N_REQ-1, sel=0, counter=0, err=0. This holds at any point, including mid-grant.
- During reset all outputs are 0: j, k, gnt, busy, err.
- All outputs are decoded from registered state, sel and err only. There is no combinational path from req or dev_out to any output.
- States: IDLE, ON_REQ, GRANT, OFF_REQ.
- IDLE: j=k=0, gnt=0.
  - If req!=0, sel is set to the first asserted index searching (last+1) mod N_REQ upward with wrap.
  - Then go to ON_REQ. If req=0, stay in IDLE.
- ON_REQ: j=1, k=0.
  - If req[sel]=0, go to OFF_REQ (abort). Abort takes priority over dev_out.
  - Else if dev_out=1, go to GRANT and clear the counter.
  - Else stay.
- GRANT: gnt[sel]=1, j=k=0, counter increments each cycle.
  - Go to OFF_REQ when req[sel]=0 or counter==HOLD_CYCLES-1.
  - Grant therefore lasts at most HOLD_CYCLES cycles.
- OFF_REQ: k=1, j=0.
  - When dev_out=0, go to IDLE and set last=sel.
- j and k are never both 1.
- Requests arriving while busy are ignored until the next IDLE.
- A grant never extends beyond HOLD_CYCLES, even if req[sel] stays high.
- Fairness: a requester that just held the grant is lowest priority in the next arbitration.
  - With req constant and all bits high, grant order is 0,1,2,3,0,...
- The counter saturates and never wraps within a state.

Optional Feature:
- Macro ONOFF_SCHED_TIMEOUT_EN.
- Defined:
  - The counter is cleared on entry to ON_REQ and OFF_REQ and counts while waiting for dev_out.
  - On reaching TIMEOUT_CYCLES without the expected dev_out value, err is set to 1 and the block goes to IDLE with j=k=0.
  - err is sticky; only reset_n clears it. Arbitration continues normally after a timeout.
- Undefined:
  - ON_REQ and OFF_REQ wait indefinitely.
  - err is tied to 0; the port remains present.

Test Plan:
- Reset behaviour: assert reset_n=0 mid-GRANT -> j, k, gnt, busy drop to 0 immediately without a clock edge; after release, req=4'b1111 -> first grant gnt=4'b0001.
- Single requester: req=4'b0100 held, bench resource echoes j/k one cycle later ->
  - ON_REQ 1 edge after request, with j=1.
  - gnt=4'b0100 for exactly 8 cycles.
  - Then k=1 until dev_out=0, then IDLE, busy=0.
- Round-robin: req=4'b1111 held for 4 full grants -> gnt sequence 0001, 0010, 0100, 1000. Then req=4'b1001 -> next grant 0001.
- Early release and abort:
  - Drop req[sel] on the 3rd GRANT cycle -> OFF_REQ next edge; gnt high for 3 cycles.
  - Drop req[sel] in ON_REQ with dev_out held 0 -> OFF_REQ with no gnt pulse.
- Timeout (ONOFF_SCHED_TIMEOUT_EN defined): dev_out stuck at 0 in ON_REQ -> after 15 cycles err=1, state IDLE, j=0.
  - err stays 1 through later grants until reset_n.
  - Without the macro, same stimulus -> j stays 1 and err=0.
